spi_xform_slave: RTL

- Parametrised SPI-mode-0 slave peripheral. It receives a WIDTH-bit frame on MOSI, applies a selectable transform, and returns the result on MISO in the same chip-select window.
- Generalises the fixed 8-bit bit-reversal SPI test slave. Adds configurable frame width, a transform mode, and a system-clock-domain implementation with synchronisers.
- Exposes received data, a frame-done pulse and a frame counter to local logic.
- Sits on the SoC SPI master bus as a loop-back/test target.

---
 rtl/spi_xform_slave.sv | 136 +++++++++++++
 1 files changed

// File: rtl/spi_xform_slave.sv
// SPI mode-0 slave: receives a WIDTH-bit frame on MOSI, returns a transformed
// copy on MISO in the same select window. All logic runs on the system clock.
module spi_xform_slave #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [1:0]       mode,
  input  logic             spi_sck,
  input  logic             spi_ss,
  input  logic             spi_mosi,
  output logic             spi_miso,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RX, TX} state_t;
  typedef enum logic [1:0] {XF_REV, XF_ECHO, XF_INV, XF_INC} xform_t;

  logic [SYNC_STAGES-1:0] sck_pipe;
  logic [SYNC_STAGES-1:0] ss_pipe;
  logic [SYNC_STAGES-1:0] mosi_pipe;
  logic                   sck_prev;

  logic                   sck_s;
  logic                   mosi_s;
  logic                   sel;
  logic                   rise;

  state_t                 state;
  logic [CW-1:0]          bit_cnt;
  logic [WIDTH-1:0]       rx_shift;
  logic [WIDTH-1:0]       tx_shift;
  logic [WIDTH-1:0]       rx_word;
  logic [WIDTH-1:0]       tx_word;

  function automatic logic [WIDTH-1:0] xform(input logic [WIDTH-1:0] r,
                                             input logic [1:0]       m);
    logic [WIDTH-1:0] t;
    t = r;
    case (xform_t'(m))
      XF_REV:  for (int i = 0; i < WIDTH; i++) t[i] = r[WIDTH-1-i];
      XF_ECHO: t = r;
      XF_INV:  t = ~r;
      XF_INC:  t = r + WIDTH'(1);
      default: t = r;
    endcase
    return t;
  endfunction

  // Select idles high so a reset never looks like a fresh chip-select.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sck_pipe  <= '0;
      ss_pipe   <= '1;
      mosi_pipe <= '0;
      sck_prev  <= 1'b0;
    end else begin
      sck_pipe  <= {sck_pipe[SYNC_STAGES-2:0], spi_sck};
      ss_pipe   <= {ss_pipe[SYNC_STAGES-2:0], spi_ss};
      mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], spi_mosi};
      sck_prev  <= sck_pipe[SYNC_STAGES-1];
    end
  end

  // MOSI is synchronised through the same depth as SCK, so it stays aligned
  // with the detected rising edge.
  assign sck_s   = sck_pipe[SYNC_STAGES-1];
  assign mosi_s  = mosi_pipe[SYNC_STAGES-1];
  assign sel     = ~ss_pipe[SYNC_STAGES-1];
  assign rise    = sck_s & ~sck_prev;
  assign rx_word = {rx_shift[WIDTH-2:0], mosi_s};
  assign tx_word = xform(rx_word, mode);

  // NOTE: every flop here updates with <= so all branches see pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      spi_miso  <= 1'b1;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (!sel) begin
        // Deselect wins over a coincident sck edge and drops any partial frame.
        state    <= IDLE;
        bit_cnt  <= '0;
        rx_shift <= '0;
        tx_shift <= '0;
        spi_miso <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            state    <= RX;
            bit_cnt  <= '0;
            spi_miso <= 1'b0;
          end
          RX: begin
            spi_miso <= 1'b0;
            if (rise) begin
              rx_shift <= rx_word;
              bit_cnt  <= bit_cnt + CW'(1);
              if (bit_cnt == CW'(WIDTH-1)) begin
                rx_data   <= rx_word;
                rx_valid  <= 1'b1;
                frame_cnt <= frame_cnt + CNT_W'(1);
                tx_shift  <= tx_word;
                spi_miso  <= tx_word[WIDTH-1];
                bit_cnt   <= '0;
                state     <= TX;
              end
            end
          end
          TX: begin
            // Zeros shift in behind the word, so MISO reads 0 once it is out.
            if (rise) begin
              tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
              spi_miso <= tx_shift[WIDTH-2];
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
